// File: rtl/commit_arbiter.sv
// Commit arbiter: round-robin collection of ALU results into one registered
// register-file write port, with error results trapped into an exception record.
module commit_arbiter #(
  parameter int unsigned N_ALU      = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_ALU-1:0]              alu_valid,
  input  logic [N_ALU*XLEN-1:0]         alu_res,
  input  logic [N_ALU*REG_ADDR_W-1:0]   alu_rd,
  input  logic [N_ALU-1:0]              alu_error,
  output logic [N_ALU-1:0]              alu_clear,
  output logic                          rf_we,
  output logic [REG_ADDR_W-1:0]         rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic                          exc_valid,
  output logic [$clog2(N_ALU)-1:0]      exc_src,
  output logic [REG_ADDR_W-1:0]         exc_rd,
  input  logic                          exc_ack,
  output logic [31:0]                   commit_count
);

  localparam int unsigned PTR_W = $clog2(N_ALU);
  localparam int unsigned SUM_W = PTR_W + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     ptr_nx;
  logic [SUM_W-1:0]     cand;
  logic                 found;
  logic                 grant_valid;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [XLEN-1:0]      win_res;
  logic                 win_err;

  // First valid at or after ptr, ascending with wrap.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < N_ALU; k++) begin
      cand = SUM_W'(ptr) + SUM_W'(k);
      if (cand >= SUM_W'(N_ALU)) cand = cand - SUM_W'(N_ALU);
      if (!found && alu_valid[cand[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant_valid = found && (state == RUN) && !rst;
    alu_clear   = grant_valid ? (N_ALU'(1) << grant_idx) : '0;
    ptr_nx      = (grant_idx == PTR_W'(N_ALU - 1)) ? '0 : grant_idx + PTR_W'(1);
    win_rd      = alu_rd[grant_idx*REG_ADDR_W +: REG_ADDR_W];
    win_res     = alu_res[grant_idx*XLEN +: XLEN];
    win_err     = alu_error[grant_idx];
  end

  // State, pointer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      ptr          <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      exc_valid    <= 1'b0;
      exc_src      <= '0;
      exc_rd       <= '0;
      commit_count <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        RUN: begin
          if (grant_valid) begin
            ptr <= ptr_nx;
            if (win_err) begin
              exc_valid <= 1'b1;
              exc_src   <= grant_idx;
              exc_rd    <= win_rd;
              state     <= HALT;
            end else begin
              commit_count <= commit_count + 32'd1;
              // x0 retires without a write; address/data keep their last value.
              if (win_rd != '0) begin
                rf_we    <= 1'b1;
                rf_waddr <= win_rd;
                rf_wdata <= win_res;
              end
            end
          end
        end
        HALT: begin
          if (exc_ack) begin
            exc_valid <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
